// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the MIPS shared-memory arbiter.
//   state_t      - arbiter FSM states (IDLE, DATA, INSTR, RESP)
//   owner_t      - which core port owns the current memory transaction
//   TIMEOUT_DATA - read data returned to the owner when the watchdog fires
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips_mem_arbiter_watchdog.sv
// mips_mem_watchdog: wait-cycle counter for the arbiter's memory timeout.
// Built only when MIPS_MEM_TIMEOUT_EN is defined.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   run        - high while a memory request is outstanding
//   clear      - restart the count (asserted while the arbiter is idle)
//   expired    - high in the TIMEOUT_CYCLES-th consecutive waiting cycle
module mips_mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Number of waiting cycles already completed before the current one.
    logic [CNT_W-1:0] count_reg;

    // The current waiting cycle is the last one allowed when the count of
    // completed cycles is one short of the limit.
    assign expired = run && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (run && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: merges the core's fetch port and data port onto one
// single-ported, variable-latency memory and produces the pipeline stall.
// Data requests have fixed priority over fetch.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   if_req/if_addr                  - fetch request, held until if_ready
//   if_rdata/if_ready               - fetched word and one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata       - data request, held until d_ready
//   d_rdata/d_ready                 - load data and one-cycle done pulse
//   stall                           - combinational pipeline stall
//   mem_req/mem_we/mem_addr/mem_wdata - registered memory request
//   mem_ack/mem_rdata               - memory acknowledge with read data
//   err                             - sticky timeout flag
// Optional feature: define MIPS_MEM_TIMEOUT_EN to build the watchdog that
// abandons a memory access after TIMEOUT_CYCLES waiting cycles.
import mips_mem_pkg::*;

module mips_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    state_t            state_reg;
    owner_t            owner_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              timeout;

`ifdef MIPS_MEM_TIMEOUT_EN
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(TIMEOUT_DATA);

    logic err_reg;
    logic wd_run;
    logic wd_clear;

    assign wd_run   = (state_reg == DATA) || (state_reg == INSTR);
    assign wd_clear = (state_reg == IDLE);

    mips_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .run    (wd_run),
        .clear  (wd_clear),
        .expired(timeout)
    );

    assign err = err_reg;
`else
    // Without the watchdog the arbiter waits for mem_ack indefinitely; the
    // limit parameter is kept so both builds share one interface.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
    end

    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

    // Ready is a pure decode of two flops, so it is glitch-free and lasts
    // exactly the single RESP cycle.
    assign if_ready = (state_reg == RESP) && (owner_reg == OWN_I);
    assign d_ready  = (state_reg == RESP) && (owner_reg == OWN_D);

    assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_I;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
`ifdef MIPS_MEM_TIMEOUT_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // Data wins: it belongs to the older instruction.
                    if (d_req) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= d_we;
                        mem_addr_reg  <= d_addr;
                        mem_wdata_reg <= d_wdata;
                        state_reg     <= DATA;
                    end else if (if_req) begin
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= if_addr;
                        state_reg    <= INSTR;
                    end
                end
                DATA, INSTR: begin
                    // An ack in the expiry cycle still completes normally.
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= RESP;
                        if (state_reg == DATA) begin
                            owner_reg   <= OWN_D;
                            d_rdata_reg <= mem_rdata;
                        end else begin
                            owner_reg    <= OWN_I;
                            if_rdata_reg <= mem_rdata;
                        end
                    end else if (timeout) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= RESP;
`ifdef MIPS_MEM_TIMEOUT_EN
                        err_reg     <= 1'b1;
                        if (state_reg == DATA) begin
                            owner_reg   <= OWN_D;
                            d_rdata_reg <= TIMEOUT_RDATA;
                        end else begin
                            owner_reg    <= OWN_I;
                            if_rdata_reg <= TIMEOUT_RDATA;
                        end
`endif
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter: directed scenarios driven through
// per-port request queues, a latency-programmable memory responder, and a
// transaction-timeline model checked against the DUT on every cycle.
module tb_mips_mem_arbiter;

    localparam int TO = 8;
`ifdef MIPS_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    always #5 clk = ~clk;

    mips_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory contents (responder and model copies) ----------
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] sh_mem[logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // ---------------- core-side request queues and drivers -------------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t if_q[$];
    req_t d_q[$];
    req_t drv_r;
    bit   abort = 1'b0;
    bit   if_seen = 1'b0;
    bit   d_seen = 1'b0;

    // A port keeps req high and swaps in its next request the cycle after its
    // ready pulse, like a core that advances as soon as the stall clears.
    always @(posedge clk) begin
        #1;
        if (abort) begin
            if_req = 1'b0;
            d_req  = 1'b0;
            if_q.delete();
            d_q.delete();
        end else begin
            if (if_req && if_seen) if_req = 1'b0;
            if (!if_req && if_q.size() > 0) begin
                drv_r   = if_q.pop_front();
                if_req  = 1'b1;
                if_addr = drv_r.addr;
            end
            if (d_req && d_seen) d_req = 1'b0;
            if (!d_req && d_q.size() > 0) begin
                drv_r   = d_q.pop_front();
                d_req   = 1'b1;
                d_we    = drv_r.we;
                d_addr  = drv_r.addr;
                d_wdata = drv_r.wdata;
            end
        end
    end

    // ---------------- memory responder --------------------------------------
    int ack_lat = 0;   // ack this many cycles after mem_req first rises; -1 = never
    int wcnt = 0;
    bit spurious = 1'b0;

    always @(posedge clk) begin
        #1;
        if (spurious) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_0BAD;
        end else if (!mem_req || mem_ack) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else begin
            if (ack_lat >= 0 && wcnt == ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
            end
            wcnt++;
        end
    end

    // ---------------- timeline model ----------------------------------------
    // A transaction is sampled in cycle s, occupies memory from s+1 until its
    // completion cycle k (ack or timeout), reports in k+1, and the next
    // request can be sampled from k+2 on.
    bit          m_act = 1'b0;
    int          m_start = 0;
    bit          m_own_d = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    int          m_rc = -1;
    bit          m_r_d = 1'b0;
    bit          m_r_we = 1'b0;
    int          m_free = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_if_rd = '0;
    logic [31:0] m_d_rd = '0;
    logic [31:0] m_v;
    bit          m_done;
    bit          m_timed;

    always @(posedge clk) begin
        if (reset) begin
            m_act   = 1'b0;
            m_rc    = -1;
            m_free  = cyc + 1;
            m_err   = 1'b0;
            m_if_rd = '0;
            m_d_rd  = '0;
        end else if (m_act) begin
            m_done  = mem_ack;
            m_timed = !mem_ack && TO_EN && (cyc - m_start == TO);
            if (m_done || m_timed) begin
                if (m_timed) begin
                    m_v   = 32'hDEAD_BEEF;
                    m_err = 1'b1;
                end else begin
                    m_v = sh_mem.exists(m_addr) ? sh_mem[m_addr] : dflt(m_addr);
                    if (m_we) sh_mem[m_addr] = m_wdata;
                end
                if (m_own_d) m_d_rd = m_v;
                else         m_if_rd = m_v;
                m_act  = 1'b0;
                m_rc   = cyc + 1;
                m_r_d  = m_own_d;
                m_r_we = m_we;
                m_free = cyc + 2;
            end
        end else if (cyc >= m_free && (d_req || if_req)) begin
            m_act   = 1'b1;
            m_start = cyc;
            m_own_d = d_req;
            if (d_req) begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else begin
                m_we   = 1'b0;
                m_addr = if_addr;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare -------------------------------------
    bit e_ir;
    bit e_dr;

    always @(negedge clk) begin
        if (cyc > 0) begin
            e_ir = (m_rc == cyc) && !m_r_d;
            e_dr = (m_rc == cyc) && m_r_d;
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_act});
            if (m_act) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_ready", {31'd0, if_ready}, {31'd0, e_ir});
            chk("d_ready", {31'd0, d_ready}, {31'd0, e_dr});
            if (e_ir) chk("if_rdata", if_rdata, m_if_rd);
            if (e_dr && !m_r_we) chk("d_rdata", d_rdata, m_d_rd);
            chk("stall", {31'd0, stall},
                {31'd0, (if_req & ~e_ir) | (d_req & ~e_dr)});
            chk("err", {31'd0, err}, {31'd0, m_err});
        end
    end

    // ---------------- event monitor -----------------------------------------
    bit          prev_mreq = 1'b0;
    int          last_rise = 0, prev_rise = 0;
    logic [31:0] rise_addr = '0, rise_wdata = '0;
    logic        rise_we = 1'b0;
    int          last_ir = 0, prev_ir = 0, last_dr = 0;
    logic [31:0] ir_data = '0, dr_data = '0;
    int          n_ir = 0, n_dr = 0, n_overlap = 0;

    always @(negedge clk) begin
        if_seen = if_ready;
        d_seen  = d_ready;
        if (mem_req && !prev_mreq) begin
            prev_rise  = last_rise;
            last_rise  = cyc;
            rise_addr  = mem_addr;
            rise_we    = mem_we;
            rise_wdata = mem_wdata;
        end
        prev_mreq = mem_req;
        if (if_ready && d_ready) n_overlap++;
        if (if_ready) begin
            prev_ir = last_ir;
            last_ir = cyc;
            ir_data = if_rdata;
            n_ir++;
            $display("txn cycle=%0d port=I addr=%h rdata=%h err=%b", cyc, rise_addr, if_rdata, err);
        end
        if (d_ready) begin
            last_dr = cyc;
            dr_data = d_rdata;
            n_dr++;
            $display("txn cycle=%0d port=D addr=%h we=%b rdata=%h err=%b", cyc, rise_addr, rise_we, d_rdata, err);
        end
    end

    // ---------------- scenario helpers --------------------------------------
    task automatic wait_quiet();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((if_q.size() > 0 || d_q.size() > 0 || if_req || d_req || mem_req) && n < 300);
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_quiet: still busy after %0d cycles, required idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_if(input logic [31:0] a);
        req_t r;
        r.we = 1'b0; r.addr = a; r.wdata = '0;
        if_q.push_back(r);
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd;
        d_q.push_back(r);
    endtask

    int n_before;
    int wn;

    initial begin
        mem_arr[32'h40] = 32'h2008_0005;
        sh_mem[32'h40]  = 32'h2008_0005;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Fetch only, ack 3 cycles after mem_req
        ack_lat = 3;
        push_if(32'h40);
        wait_quiet();
        chk("fetch_addr", rise_addr, 32'h40);
        chk("fetch_we", {31'd0, rise_we}, 32'd0);
        chk("fetch_rdata", ir_data, 32'h2008_0005);
        chk("fetch_latency", last_ir - last_rise, 32'd4);

        // Store, ack latency 1, then load it back
        ack_lat = 1;
        push_d(1'b1, 32'h54, 32'h7);
        wait_quiet();
        chk("store_addr", rise_addr, 32'h54);
        chk("store_we", {31'd0, rise_we}, 32'd1);
        chk("store_wdata", rise_wdata, 32'h7);
        chk("store_ready", last_dr - last_rise, 32'd2);
        ack_lat = 2;
        push_d(1'b0, 32'h54, 32'h0);
        wait_quiet();
        chk("load_back", dr_data, 32'h7);

        // Contention: data first, fetch five cycles later
        ack_lat = 2;
        push_d(1'b0, 32'h100, 32'h0);
        push_if(32'h200);
        wait_quiet();
        chk("cont_order", last_ir - last_dr, 32'd5);
        chk("cont_fetch_data", ir_data, dflt(32'h200));
        chk("cont_load_data", dr_data, dflt(32'h100));

        // Back-to-back fetches, ack in the first waiting cycle
        ack_lat = 0;
        push_if(32'h300);
        push_if(32'h304);
        wait_quiet();
        chk("b2b_first_ready", prev_ir - prev_rise, 32'd1);
        chk("b2b_req_gap", last_rise - prev_rise, 32'd3);
        chk("b2b_second_addr", rise_addr, 32'h304);
        chk("overlap", n_overlap, 32'd0);

        // Stray ack while idle is ignored
        n_before = n_ir + n_dr;
        spurious = 1'b1;
        @(negedge clk);
        spurious = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ack", n_ir + n_dr, n_before);

        // Reset two cycles into a DATA wait
        ack_lat = -1;
        n_before = n_dr;
        push_d(1'b0, 32'h80, 32'h0);
        wn = 0;
        while (!mem_req && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        chk("rst_mid_started", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        abort = 1'b1;
        #1 reset = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_mid_d_rdata", d_rdata, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_ready", n_dr, n_before);

`ifdef MIPS_MEM_TIMEOUT_EN
        // Ack coincident with expiry: ack wins
        ack_lat = 7;
        push_d(1'b0, 32'h90, 32'h0);
        wait_quiet();
        chk("to_tie_err", {31'd0, err}, 32'd0);
        chk("to_tie_data", dr_data, dflt(32'h90));
        // Memory never acks
        ack_lat = -1;
        push_d(1'b0, 32'hA0, 32'h0);
        wait_quiet();
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_data", dr_data, 32'hDEAD_BEEF);
        chk("to_latency", last_dr - last_rise, 32'd8);
        // Next request proceeds normally, err stays set
        ack_lat = 1;
        push_if(32'h40);
        wait_quiet();
        chk("to_after_data", ir_data, 32'h2008_0005);
        chk("to_after_err", {31'd0, err}, 32'd1);
`else
        chk("err_tied", {31'd0, err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
